// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a bounded
// grant tenure. All outputs are registered; winner selection is combinational.
module rr_ring_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
    localparam logic [N-1:0]     LSB_HOT   = N'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [N-1:0]     ptr_r, ptr_s;
    logic [CNT_W-1:0] hold_r, hold_s;
    logic [N-1:0]     grant_r, grant_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             busy_r, busy_s;
    logic             timeout_r, timeout_s;
    logic             owner_req_s;
    logic [N-1:0]     cand_s;
    logic [IDX_W:0]   pick_s;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] res;
        res = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (v[i]) res = IDX_W'(i);
            else      res = res;
        end
        return res;
    endfunction

    // Returns {found, index} of the first set bit at or circularly after start;
    // scanning from the far end lets the nearest candidate overwrite the rest.
    function automatic logic [IDX_W:0] pick(input logic [N-1:0] r,
                                            input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        int             j;
        res = {(IDX_W+1){1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            else        j = j;
            if (r[j]) res = {1'b1, IDX_W'(j)};
            else      res = res;
        end
        return res;
    endfunction

    // Next-state: tenure bookkeeping, pointer rotation and same-edge handoff.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        hold_s      = hold_r;
        grant_s     = grant_r;
        idx_s       = idx_r;
        timeout_s   = 1'b0;
        owner_req_s = req[idx_r];
        cand_s      = req;
        pick_s      = {(IDX_W+1){1'b0}};
        case (state_r)
            ST_IDLE: begin
                pick_s = pick(req, onehot_to_idx(ptr_r));
            end
            ST_GRANT: begin
                if (owner_req_s && (hold_r < HOLD_LAST)) begin
                    hold_s = hold_r + HOLD_ONE;
                end else begin
                    // Old owner drops to lowest priority; mask it only on release.
                    timeout_s = owner_req_s;
                    ptr_s     = {grant_r[N-2:0], grant_r[N-1]};
                    cand_s    = owner_req_s ? req : (req & ~grant_r);
                    pick_s    = pick(cand_s, onehot_to_idx(ptr_s));
                end
            end
            default: begin
                pick_s = {(IDX_W+1){1'b0}};
            end
        endcase

        if ((state_r != ST_GRANT) || !owner_req_s || (hold_r >= HOLD_LAST)) begin
            if (en && pick_s[IDX_W]) begin
                state_s = ST_GRANT;
                grant_s = LSB_HOT << pick_s[IDX_W-1:0];
                idx_s   = pick_s[IDX_W-1:0];
                hold_s  = {CNT_W{1'b0}};
            end else begin
                state_s = ST_IDLE;
                grant_s = {N{1'b0}};
                idx_s   = {IDX_W{1'b0}};
                hold_s  = {CNT_W{1'b0}};
            end
        end else begin
            state_s = state_r;
        end
        busy_s = |grant_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= LSB_HOT;
            hold_r    <= {CNT_W{1'b0}};
            grant_r   <= {N{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            hold_r    <= hold_s;
            grant_r   <= grant_s;
            idx_r     <= idx_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    assign grant     = grant_r;
    assign grant_idx = idx_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;

endmodule
